// File: rtl/irq_coalescer.sv
// Interrupt moderation: counts rising edges of a synchronized interrupt level and
// raises a level interrupt on a count threshold or a timeout since the first event.
module irq_coalescer #(
    parameter int COUNT_WIDTH = 8,
    parameter int THRESHOLD   = 4,
    parameter int TIMER_WIDTH = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   irq_in,
    input  logic                   irq_ack,
    output logic                   irq_out,
    output logic [COUNT_WIDTH-1:0] pending_count,
    output logic                   overflow,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FIRE  = 2'd2
    } state_e;

    localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] THRESH_C   = COUNT_WIDTH'(THRESHOLD);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_M1 = TIMER_WIDTH'(TIMEOUT - 1);
    localparam bit                     THR_ONE    = (THRESHOLD == 1);

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   ovf_q, ovf_d;
    logic                   irq_d_q;
    logic                   irq_out_q, irq_out_d;
    logic                   irq_edge;
    logic [COUNT_WIDTH-1:0] count_inc;

    // irq_d_q resets to 0, so a level already high at reset release is one event.
    assign irq_edge = irq_in & ~irq_d_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        ovf_d     = ovf_q;
        count_inc = count_q + COUNT_WIDTH'(irq_edge);
        case (state_q)
            IDLE: begin
                count_d = '0;
                timer_d = '0;
                if (irq_edge) begin
                    count_d = CNT_ONE;
                    state_d = THR_ONE ? FIRE : ACCUM;
                end
            end
            ACCUM: begin
                timer_d = timer_q + TIMER_WIDTH'(1);
                count_d = count_inc;
                if ((irq_edge && (count_inc >= THRESH_C)) || (timer_q == TIMEOUT_M1)) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                if (irq_ack) begin
                    ovf_d   = 1'b0;
                    timer_d = '0;
                    // An edge coincident with the ack starts the next batch.
                    if (irq_edge) begin
                        count_d = CNT_ONE;
                        state_d = THR_ONE ? FIRE : ACCUM;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                end else if (irq_edge) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        irq_out_d = (state_d == FIRE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            timer_q   <= '0;
            ovf_q     <= 1'b0;
            irq_d_q   <= 1'b0;
            irq_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            ovf_q     <= ovf_d;
            irq_d_q   <= irq_in;
            irq_out_q <= irq_out_d;
        end
    end

    assign irq_out       = irq_out_q;
    assign pending_count = count_q;
    assign overflow      = ovf_q;
    assign state_dbg     = state_q;

endmodule
